// File: rtl/rt_mem_requester.sv
// Single-outstanding requester bridging the core data port to racetrack memory.
// Optional WAIT timeout with error response: define RT_TIMEOUT_EN.
module rt_mem_requester #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic [DATA_WIDTH-1:0] data_mask_i,
    input  logic [7:0]            data_lim_funct_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,
    output logic                  en_ab_o,
    output logic                  write_pulse_o,
    output logic                  read_pulse_o,
    output logic                  range_active_o,
    output logic                  write_en_data_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [3:0]            be_b_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic [DATA_WIDTH-1:0] mask_o,
    output logic [7:0]            lim_funct_o,
    input  logic [DATA_WIDTH-1:0] r_data_i,
    input  logic                  r_valid_i
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic                  req_we;
    logic [3:0]            req_be;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_mask;
    logic [7:0]            req_lim;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  grant;
    logic                  timeout;
    logic                  active;

    // No grant while reset is asserted: the edge would not take effect.
    assign grant = data_req_i && (state == IDLE) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (grant) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (r_valid_i || timeout) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_we    <= 1'b0;
            req_be    <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_mask  <= '0;
            req_lim   <= '0;
        end else if (grant) begin
            req_we    <= data_we_i;
            req_be    <= data_be_i;
            req_addr  <= data_addr_i;
            req_wdata <= data_wdata_i;
            req_mask  <= data_mask_i;
            req_lim   <= data_lim_funct_i;
        end
    end

    // Writes complete with zero read data; a timeout also returns zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (state == WAIT && r_valid_i) begin
            rdata_q <= req_we ? '0 : r_data_i;
        end else if (timeout) begin
            rdata_q <= '0;
        end
    end

`ifdef RT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // r_valid_i on the last WAIT cycle wins over the timeout.
    assign timeout = (state == WAIT) && !r_valid_i
                   && (wait_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (state == WAIT && r_valid_i) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign data_err_o = err_q;
`else
    assign timeout    = 1'b0;
    assign data_err_o = 1'b0;
`endif

    assign active = (state == ISSUE) || (state == WAIT);

    assign data_gnt_o      = grant;
    assign data_rvalid_o   = (state == RESP);
    assign data_rdata_o    = rdata_q;
    assign en_ab_o         = active;
    assign range_active_o  = active;
    assign read_pulse_o    = (state == ISSUE) && !req_we;
    assign write_pulse_o   = (state == ISSUE) && req_we;
    assign write_en_data_o = (state == ISSUE) && req_we && (req_lim == 8'd0);
    assign addr_o          = active ? req_addr  : '0;
    assign be_b_o          = active ? req_be    : '0;
    assign write_data_o    = active ? req_wdata : '0;
    assign mask_o          = active ? req_mask  : '0;
    assign lim_funct_o     = active ? req_lim   : '0;

endmodule
